// File: rtl/battleship_pkg.sv
// Shared constants, state encoding and cell-index helper for the PC shot engine.
package battleship_pkg;

    localparam int GRID_N_DEFAULT = 5;
    localparam int IDX_W          = 3;   // row/column width (grid side <= 8)
    localparam int CELL_W         = 6;   // flat cell index width (up to 64 cells)

    // Fibonacci feedback taps 8,6,5,4 -> bits 7,5,4,3 of the shift register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SCAN  = 3'd3,
        ST_FIRE  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Flat cell index i*n + j, evaluated at CELL_W bits.
    function automatic logic [CELL_W-1:0] cell_idx(input logic [IDX_W-1:0] i,
                                                   input logic [IDX_W-1:0] j,
                                                   input int n);
        cell_idx = CELL_W'(i) * CELL_W'(n) + CELL_W'(j);
    endfunction

endpackage

// File: rtl/pc_shot_engine_if.sv
// Signal bundle between the game FSM side (master) and the PC shot engine (slave).
// Strobe semantics: there is no back-pressure. shot_valid and turn_done are
// single-cycle strobes the consumer must sample on the cycle they are high;
// shot_i/shot_j/shot_hit are valid with shot_valid and hold until the next shot.
interface pc_shot_engine_if #(parameter int GRID_N = 5);
    import battleship_pkg::*;

    logic                       new_game;
    logic [2:0]                 amount_of_ships;
    logic                       pc_turn;
    logic [GRID_N*GRID_N-1:0]   player_board;
    logic [IDX_W-1:0]           shot_i;
    logic [IDX_W-1:0]           shot_j;
    logic                       shot_valid;
    logic                       shot_hit;
    logic [2:0]                 player_ships_left;
    logic                       turn_done;
    logic                       no_target;
    logic                       busy;
    state_t                     dbg_state;

    modport master (
        output new_game, amount_of_ships, pc_turn, player_board,
        input  shot_i, shot_j, shot_valid, shot_hit, player_ships_left,
        input  turn_done, no_target, busy, dbg_state
    );

    modport slave (
        input  new_game, amount_of_ships, pc_turn, player_board,
        output shot_i, shot_j, shot_valid, shot_hit, player_ships_left,
        output turn_done, no_target, busy, dbg_state
    );

endinterface

// File: rtl/pc_shot_engine_lfsr_gen.sv
// Free-running 8-bit Fibonacci LFSR; a non-zero seed keeps it out of the all-zero lock-up state.
module lfsr_gen
    import battleship_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // State register, advances every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/pc_shot_engine.sv
// Computer-opponent turn engine: picks an unfired cell, resolves hit/miss, tracks player ships.
module pc_shot_engine
    import battleship_pkg::*;
#(
    parameter int         GRID_N    = GRID_N_DEFAULT,
    parameter int         MAX_TRIES = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    pc_shot_engine_if.slave   bus
);

    localparam int NCELL = GRID_N * GRID_N;
    localparam int TRY_W = $clog2(MAX_TRIES) + 1;

    state_t                 state_q, state_d;
    logic                   pc_turn_q;
    logic [IDX_W-1:0]       cand_i_q, cand_i_d, cand_j_q, cand_j_d;
    logic [IDX_W-1:0]       scan_i_q, scan_i_d, scan_j_q, scan_j_d;
    logic [TRY_W-1:0]       tries_q, tries_d;
    logic [63:0]            hist_q, hist_d;         // one bit per flat cell index
    logic [6:0]             shot_count_q, shot_count_d;
    logic [2:0]             ships_q, ships_d;
    logic [IDX_W-1:0]       shot_i_q, shot_i_d, shot_j_q, shot_j_d;
    logic                   shot_hit_q, shot_hit_d;
    logic                   no_target_q, no_target_d;

    logic [7:0]             lfsr;
    logic                   lfsr_unused;
    logic                   rise;
    logic [63:0]            board_ext;
    logic [CELL_W-1:0]      cand_idx, scan_idx;
    logic                   cand_in_range;

    lfsr_gen #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign lfsr_unused   = ^lfsr[7:6];
    assign rise          = bus.pc_turn & ~pc_turn_q;
    assign board_ext     = 64'(bus.player_board);
    assign cand_idx      = cell_idx(cand_i_q, cand_j_q, GRID_N);
    assign scan_idx      = cell_idx(scan_i_q, scan_j_q, GRID_N);
    assign cand_in_range = ({1'b0, cand_i_q} < 4'(GRID_N)) && ({1'b0, cand_j_q} < 4'(GRID_N));

    // Next-state and datapath updates; new_game overrides everything at the end.
    always_comb begin
        state_d      = state_q;
        cand_i_d     = cand_i_q;
        cand_j_d     = cand_j_q;
        scan_i_d     = scan_i_q;
        scan_j_d     = scan_j_q;
        tries_d      = tries_q;
        hist_d       = hist_q;
        shot_count_d = shot_count_q;
        ships_d      = ships_q;
        shot_i_d     = shot_i_q;
        shot_j_d     = shot_j_q;
        shot_hit_d   = shot_hit_q;
        no_target_d  = no_target_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d     = ST_PICK;
                    tries_d     = '0;
                    no_target_d = 1'b0;
                end
            end
            ST_PICK: begin
                if (shot_count_q == 7'(NCELL)) begin
                    no_target_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cand_i_d = lfsr[2:0];
                    cand_j_d = lfsr[5:3];
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cand_in_range && !hist_q[cand_idx]) begin
                    state_d = ST_FIRE;
                end else begin
                    tries_d = tries_q + 1'b1;
                    if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                        state_d  = ST_SCAN;
                        scan_i_d = '0;
                        scan_j_d = '0;
                    end else begin
                        state_d = ST_PICK;
                    end
                end
            end
            ST_SCAN: begin
                // An unfired cell must exist, since PICK already ruled out a full grid.
                if (!hist_q[scan_idx]) begin
                    cand_i_d = scan_i_q;
                    cand_j_d = scan_j_q;
                    state_d  = ST_FIRE;
                end else if (scan_j_q == IDX_W'(GRID_N - 1)) begin
                    scan_j_d = '0;
                    scan_i_d = scan_i_q + 1'b1;
                end else begin
                    scan_j_d = scan_j_q + 1'b1;
                end
            end
            ST_FIRE: begin
                shot_i_d         = cand_i_q;
                shot_j_d         = cand_j_q;
                shot_hit_d       = board_ext[cand_idx];
                hist_d[cand_idx] = 1'b1;
                shot_count_d     = shot_count_q + 1'b1;
                if (board_ext[cand_idx] && (ships_q != 3'd0)) ships_d = ships_q - 1'b1;
                state_d          = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.new_game) begin
            state_d      = ST_IDLE;
            hist_d       = '0;
            shot_count_d = '0;
            ships_d      = bus.amount_of_ships;
            shot_hit_d   = 1'b0;
            no_target_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_turn_q    <= 1'b0;
            cand_i_q     <= '0;
            cand_j_q     <= '0;
            scan_i_q     <= '0;
            scan_j_q     <= '0;
            tries_q      <= '0;
            hist_q       <= '0;
            shot_count_q <= '0;
            ships_q      <= '0;
            shot_i_q     <= '0;
            shot_j_q     <= '0;
            shot_hit_q   <= 1'b0;
            no_target_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_turn_q    <= bus.pc_turn;
            cand_i_q     <= cand_i_d;
            cand_j_q     <= cand_j_d;
            scan_i_q     <= scan_i_d;
            scan_j_q     <= scan_j_d;
            tries_q      <= tries_d;
            hist_q       <= hist_d;
            shot_count_q <= shot_count_d;
            ships_q      <= ships_d;
            shot_i_q     <= shot_i_d;
            shot_j_q     <= shot_j_d;
            shot_hit_q   <= shot_hit_d;
            no_target_q  <= no_target_d;
        end
    end

    // During FIRE the live candidate is presented; otherwise the last shot is held.
    assign bus.shot_valid        = (state_q == ST_FIRE);
    assign bus.shot_i            = (state_q == ST_FIRE) ? cand_i_q : shot_i_q;
    assign bus.shot_j            = (state_q == ST_FIRE) ? cand_j_q : shot_j_q;
    assign bus.shot_hit          = (state_q == ST_FIRE) ? board_ext[cand_idx] : shot_hit_q;
    assign bus.player_ships_left = ships_q;
    assign bus.turn_done         = (state_q == ST_DONE);
    assign bus.no_target         = (state_q == ST_DONE) && no_target_q;
    assign bus.busy              = (state_q != ST_IDLE);
    assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_pc_shot_engine.sv
// Directed-plus-random bench for pc_shot_engine on a 5x5 grid.
module tb_pc_shot_engine;
    import battleship_pkg::*;

    localparam int N     = 5;
    localparam int NCELL = N * N;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    // Reference model: which cells have been fired at, and the expected ship count.
    bit         fired [NCELL];
    int         ships_m;
    logic [NCELL-1:0] board_m;

    pc_shot_engine_if #(.GRID_N(N)) bus ();

    pc_shot_engine #(.GRID_N(N), .MAX_TRIES(16), .LFSR_SEED(8'h3C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fired_count();
        int c = 0;
        for (int k = 0; k < NCELL; k++) if (fired[k]) c++;
        return c;
    endfunction

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic model_shot(input int i, input int j, input logic hit);
        int idx;
        chk("in_range", (i < N) && (j < N), 1);
        idx = (i < N && j < N) ? i * N + j : 0;
        chk("fresh_cell", fired[idx], 0);
        chk("hit_value", hit, board_m[idx]);
        fired[idx] = 1'b1;
        if (board_m[idx] && ships_m > 0) ships_m--;
    endtask

    task automatic new_game(input logic [2:0] amt, input logic [NCELL-1:0] brd);
        @(negedge clk);
        bus.new_game        = 1'b1;
        bus.amount_of_ships = amt;
        bus.player_board    = brd;
        board_m             = brd;
        @(negedge clk);
        bus.new_game = 1'b0;
        for (int k = 0; k < NCELL; k++) fired[k] = 1'b0;
        ships_m = amt;
        chk("ng_ships", bus.player_ships_left, amt);
        chk("ng_busy", bus.busy, 0);
        chk("ng_hit_clr", bus.shot_hit, 0);
    endtask

    // One complete turn from a rising pc_turn; checked against the model.
    task automatic run_turn(output int oi, output int oj, output logic ohit, output logic ont);
        int   nshot, shot_cyc, done_cyc, si, sj;
        logic shit, nt, done;
        nshot = 0; shot_cyc = 0; done_cyc = 0; si = 0; sj = 0; shit = 0; nt = 0; done = 0;
        bus.pc_turn = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_pick", bus.busy, 1);
            if (bus.shot_valid) begin
                nshot++;
                shot_cyc = cyc;
                si = int'(bus.shot_i); sj = int'(bus.shot_j); shit = bus.shot_hit;
            end
            if (bus.turn_done) begin
                done = 1'b1; done_cyc = cyc; nt = bus.no_target;
                if (!nt) begin
                    chk("one_shot", nshot, 1);
                    chk("done_after_shot", done_cyc, shot_cyc + 1);
                    chk("min_latency", shot_cyc >= 3, 1);
                    model_shot(si, sj, shit);
                end else begin
                    chk("nt_cycles", done_cyc, 2);
                    chk("nt_no_shot", nshot, 0);
                end
                chk("no_target", nt, fired_count() == NCELL && !(nshot == 1));
                chk("ships_left", bus.player_ships_left, ships_m);
                break;
            end
        end
        chk("turn_timeout", done, 1);
        bus.pc_turn = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.turn_done, 0);
        if (nshot == 1) begin
            chk("hold_i", bus.shot_i, si);
            chk("hold_j", bus.shot_j, sj);
            chk("hold_hit", bus.shot_hit, shit);
        end
        oi = si; oj = sj; ohit = shit; ont = nt;
    endtask

    initial begin
        int   ti, tj, sv_cnt, td_cnt;
        logic th, tnt, scan_seen, found;
        logic [NCELL-1:0] brd;
        int   a, b;

        n_cmp = 0; n_bad = 0; ships_m = 0; board_m = '0;
        rst = 1'b0;
        bus.new_game = 1'b0; bus.amount_of_ships = 3'd0; bus.pc_turn = 1'b0; bus.player_board = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_shot_valid", bus.shot_valid, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_shot_i", bus.shot_i, 0);
        chk("rel_shot_j", bus.shot_j, 0);
        chk("rel_shot_hit", bus.shot_hit, 0);
        chk("rel_ships", bus.player_ships_left, 0);
        chk("rel_done", bus.turn_done, 0);
        chk("rel_no_target", bus.no_target, 0);
        chk("rel_busy", bus.busy, 0);
        new_game(3'd3, '0);

        // Single ship at (0,0): fire until that cell comes up.
        new_game(3'd1, NCELL'(1));
        found = 1'b0;
        for (int t = 0; t < NCELL && !found; t++) begin
            gap();
            run_turn(ti, tj, th, tnt);
            if (ti == 0 && tj == 0 && !tnt) begin
                found = 1'b1;
                chk("ship00_hit", th, 1);
                chk("ship00_left", bus.player_ships_left, 0);
            end
        end
        chk("ship00_found", found, 1);

        // Held pc_turn gives exactly one turn; a low cycle re-arms it.
        new_game(3'd4, NCELL'($urandom));
        sv_cnt = 0; td_cnt = 0;
        bus.pc_turn = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.shot_valid) begin
                sv_cnt++;
                model_shot(int'(bus.shot_i), int'(bus.shot_j), bus.shot_hit);
            end
            if (bus.turn_done) td_cnt++;
        end
        chk("held_shots", sv_cnt, 1);
        chk("held_dones", td_cnt, 1);
        bus.pc_turn = 1'b0;
        @(negedge clk);
        run_turn(ti, tj, th, tnt);
        chk("rearm_nt", tnt, 0);

        // Rise coincident with new_game is discarded.
        @(negedge clk);
        bus.new_game = 1'b1; bus.pc_turn = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        for (int k = 0; k < NCELL; k++) fired[k] = 1'b0;
        ships_m = int'(bus.amount_of_ships);
        td_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.busy) td_cnt++;
        end
        chk("ng_rise_dropped", td_cnt, 0);
        bus.pc_turn = 1'b0;
        @(negedge clk);

        // Asynchronous reset while in CHECK.
        bus.pc_turn = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.dbg_state == ST_CHECK) found = 1'b1;
        end
        chk("reach_check", found, 1);
        rst = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_valid", bus.shot_valid, 0);
        chk("arst_ships", bus.player_ships_left, 0);
        sv_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.shot_valid || bus.turn_done) sv_cnt++;
        end
        bus.pc_turn = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.shot_valid || bus.turn_done) sv_cnt++;
        end
        chk("arst_quiet", sv_cnt, 0);

        // Drive a turn into SCAN (one cell left), then abort it with new_game.
        scan_seen = 1'b0;
        for (int att = 0; att < 30 && !scan_seen; att++) begin
            new_game(3'd7, NCELL'($urandom));
            for (int k = 0; k < NCELL - 1; k++) begin
                gap();
                run_turn(ti, tj, th, tnt);
            end
            bus.pc_turn = 1'b1;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (bus.dbg_state == ST_SCAN) begin
                    scan_seen = 1'b1;
                    break;
                end
                if (bus.turn_done) break;
            end
            if (!scan_seen) begin
                bus.pc_turn = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        chk("scan_reached", scan_seen, 1);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        chk("abort_idle", bus.busy, 0);
        chk("abort_ships", bus.player_ships_left, 7);
        sv_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.shot_valid || bus.turn_done) sv_cnt++;
        end
        chk("abort_quiet", sv_cnt, 0);
        bus.pc_turn = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NCELL; k++) fired[k] = 1'b0;
        ships_m = 7;

        // Full sweep after the abort: 25 distinct shots, then an exhausted grid.
        for (int k = 0; k < NCELL; k++) begin
            gap();
            run_turn(ti, tj, th, tnt);
        end
        chk("all_cells", fired_count(), NCELL);
        gap();
        run_turn(ti, tj, th, tnt);
        chk("exhausted", tnt, 1);

        // Two ship cells but one ship: count saturates at zero.
        a = $urandom_range(0, NCELL - 1);
        b = (a + 1 + $urandom_range(0, NCELL - 2)) % NCELL;
        brd = '0; brd[a] = 1'b1; brd[b] = 1'b1;
        new_game(3'd1, brd);
        for (int k = 0; k < NCELL; k++) begin
            gap();
            run_turn(ti, tj, th, tnt);
        end
        chk("sat_zero", bus.player_ships_left, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
